// File: rtl/fwd_hazard_unit_pkg.sv
// Shared types and constants for the forwarding/hazard unit: forward-select
// encodings, the in-flight write descriptor and mult/div latency defaults.
package fwd_hazard_unit_pkg;

  localparam int unsigned SEL_W = 2;

  localparam logic [SEL_W-1:0] FWD_RF = 2'd0;
  localparam logic [SEL_W-1:0] FWD_M  = 2'd1;
  localparam logic [SEL_W-1:0] FWD_W  = 2'd2;

  // Descriptor fields are sized for the widest supported register/Tnew width.
  localparam int unsigned REG_W_MAX  = 8;
  localparam int unsigned TNEW_W_MAX = 4;

  localparam int unsigned MULT_CYC_DEF = 5;
  localparam int unsigned DIV_CYC_DEF  = 10;

  typedef struct packed {
    logic                  valid;
    logic                  wen;
    logic [REG_W_MAX-1:0]  wreg;
    logic [TNEW_W_MAX-1:0] tnew;
  } desc_t;

  // One pipeline advance: the result gets one cycle closer, never below zero.
  function automatic desc_t desc_advance(input desc_t d);
    desc_t n;
    n = d;
    if (d.tnew != '0) n.tnew = d.tnew - TNEW_W_MAX'(1);
    return n;
  endfunction

  // Register 0 is hard-wired, so it never matches a producer.
  function automatic logic desc_match(input desc_t d, input logic [REG_W_MAX-1:0] rs);
    return d.valid && d.wen && (d.wreg == rs) && (rs != '0);
  endfunction

endpackage

// File: rtl/fwd_hazard_unit_fwd_port_mux.sv
// Operand select for one E-stage read port: nearest ready producer wins
// (M with tnew==0, then W), otherwise the register-file value is kept.
module fwd_port_mux
  import fwd_hazard_unit_pkg::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5
) (
  input  logic [AW-1:0]    rs,
  input  desc_t            m_desc,
  input  desc_t            w_desc,
  input  logic [DW-1:0]    rf,
  input  logic [DW-1:0]    m_data,
  input  logic [DW-1:0]    w_data,
  output logic [SEL_W-1:0] sel,
  output logic [DW-1:0]    opnd
);

  logic m_hit;
  logic w_hit;

  assign m_hit = desc_match(m_desc, REG_W_MAX'(rs)) && (m_desc.tnew == '0);
  assign w_hit = desc_match(w_desc, REG_W_MAX'(rs));

  always_comb begin
    sel  = FWD_RF;
    opnd = rf;
    if (m_hit) begin
      sel  = FWD_M;
      opnd = m_data;
    end else if (w_hit) begin
      sel  = FWD_W;
      opnd = w_data;
    end
  end

  // A W producer always has its value ready; its countdown is irrelevant here.
  logic unused_w_tnew;
  assign unused_w_tnew = ^w_desc.tnew;

endmodule

// File: rtl/fwd_hazard_unit.sv
// Hazard/forwarding unit: E/M/W write-descriptor pipeline, Tuse/Tnew D stall,
// per-port E operand forwarding. Optional mult/div busy stall under MDU_STALL_EN.
module fwd_hazard_unit
  import fwd_hazard_unit_pkg::*;
#(
  parameter int unsigned NRP      = 2,
  parameter int unsigned DW       = 32,
  parameter int unsigned AW       = 5,
  parameter int unsigned TW       = 2,
  parameter int unsigned MULT_CYC = MULT_CYC_DEF,
  parameter int unsigned DIV_CYC  = DIV_CYC_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 d_valid,
  input  logic [NRP*AW-1:0]    d_rs,
  input  logic [NRP*TW-1:0]    d_tuse,
  input  logic                 d_wen,
  input  logic [AW-1:0]        d_wreg,
  input  logic [TW-1:0]        d_tnew,
  input  logic                 d_md_use,
  input  logic                 e_md_start,
  input  logic                 e_md_div,
  input  logic [NRP*DW-1:0]    e_rf,
  input  logic [DW-1:0]        e_fwd_data,
  input  logic [DW-1:0]        m_fwd_data,
  input  logic [DW-1:0]        w_fwd_data,
  output logic                 stall,
  output logic [NRP*DW-1:0]    e_opnd,
  output logic [NRP*SEL_W-1:0] e_fwd_sel,
  output logic                 md_busy
);

  desc_t              d_desc;
  desc_t              e_q;
  desc_t              m_q;
  desc_t              w_q;
  logic [NRP*AW-1:0]  e_rs_q;
  logic               hz_stall;
  logic               md_stall;

  always_comb begin
    d_desc       = '0;
    d_desc.valid = d_valid;
    d_desc.wen   = d_wen;
    d_desc.wreg  = REG_W_MAX'(d_wreg);
    d_desc.tnew  = TNEW_W_MAX'(d_tnew);
  end

  // Consumer must wait while an E or M producer's value is later than its use.
  always_comb begin
    hz_stall = 1'b0;
    for (int i = 0; i < NRP; i++) begin
      if (desc_match(e_q, REG_W_MAX'(d_rs[i*AW +: AW])) &&
          (e_q.tnew > TNEW_W_MAX'(d_tuse[i*TW +: TW])))
        hz_stall = 1'b1;
      if (desc_match(m_q, REG_W_MAX'(d_rs[i*AW +: AW])) &&
          (m_q.tnew > TNEW_W_MAX'(d_tuse[i*TW +: TW])))
        hz_stall = 1'b1;
    end
    hz_stall = hz_stall & d_valid;
  end

  assign stall = hz_stall | md_stall;

  // Descriptor pipeline; a stall or empty D slot inserts a bubble into E.
  always_ff @(posedge clk) begin
    if (reset) begin
      e_q    <= '0;
      m_q    <= '0;
      w_q    <= '0;
      e_rs_q <= '0;
    end else begin
      if (stall || !d_valid) begin
        e_q    <= '0;
        e_rs_q <= '0;
      end else begin
        e_q    <= d_desc;
        e_rs_q <= d_rs;
      end
      m_q <= desc_advance(e_q);
      w_q <= desc_advance(m_q);
    end
  end

  for (genvar g = 0; g < NRP; g++) begin : g_port
    fwd_port_mux #(
      .DW(DW),
      .AW(AW)
    ) u_mux (
      .rs     (e_rs_q[g*AW +: AW]),
      .m_desc (m_q),
      .w_desc (w_q),
      .rf     (e_rf[g*DW +: DW]),
      .m_data (m_fwd_data),
      .w_data (w_fwd_data),
      .sel    (e_fwd_sel[g*SEL_W +: SEL_W]),
      .opnd   (e_opnd[g*DW +: DW])
    );
  end

`ifdef MDU_STALL_EN
  localparam int unsigned MD_MAX = (DIV_CYC > MULT_CYC) ? DIV_CYC : MULT_CYC;
  localparam int unsigned CNT_W  = $clog2(MD_MAX + 1);

  logic [CNT_W-1:0] md_cnt_q;

  // Busy countdown; a new start simply reloads it.
  always_ff @(posedge clk) begin
    if (reset) begin
      md_cnt_q <= '0;
    end else if (e_md_start) begin
      md_cnt_q <= e_md_div ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
    end else if (md_cnt_q != '0) begin
      md_cnt_q <= md_cnt_q - CNT_W'(1);
    end
  end

  assign md_busy  = (md_cnt_q != '0);
  assign md_stall = d_md_use & (md_busy | e_md_start);
`else
  assign md_busy  = 1'b0;
  assign md_stall = 1'b0;

  logic unused_md;
  assign unused_md = ^{d_md_use, e_md_start, e_md_div};
`endif

  // E-stage producer data is reserved for future forwarding into D.
  logic unused_e_fwd;
  assign unused_e_fwd = ^e_fwd_data;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: directed vector table, multi-cycle corner
// sequences and a randomized run against an instruction-level reference model.
module tb_fwd_hazard_unit;

  localparam int unsigned NRP = 2;
  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 5;
  localparam int unsigned TW  = 2;
  localparam logic [31:0] RF0    = 32'hAAAA_0000;
  localparam logic [31:0] RF1    = 32'hBBBB_0000;
  localparam logic [31:0] W_DATA = 32'hDEAD_BEEF;

  logic              clk;
  logic              reset;
  logic              d_valid;
  logic [NRP*AW-1:0] d_rs;
  logic [NRP*TW-1:0] d_tuse;
  logic              d_wen;
  logic [AW-1:0]     d_wreg;
  logic [TW-1:0]     d_tnew;
  logic              d_md_use;
  logic              e_md_start;
  logic              e_md_div;
  logic [NRP*DW-1:0] e_rf;
  logic [DW-1:0]     e_fwd_data;
  logic [DW-1:0]     m_fwd_data;
  logic [DW-1:0]     w_fwd_data;
  logic              stall;
  logic [NRP*DW-1:0] e_opnd;
  logic [NRP*2-1:0]  e_fwd_sel;
  logic              md_busy;

  int checks;
  int errors;

  fwd_hazard_unit #(
    .NRP(NRP), .DW(DW), .AW(AW), .TW(TW), .MULT_CYC(5), .DIV_CYC(10)
  ) dut (
    .clk(clk), .reset(reset), .d_valid(d_valid), .d_rs(d_rs), .d_tuse(d_tuse),
    .d_wen(d_wen), .d_wreg(d_wreg), .d_tnew(d_tnew), .d_md_use(d_md_use),
    .e_md_start(e_md_start), .e_md_div(e_md_div), .e_rf(e_rf),
    .e_fwd_data(e_fwd_data), .m_fwd_data(m_fwd_data), .w_fwd_data(w_fwd_data),
    .stall(stall), .e_opnd(e_opnd), .e_fwd_sel(e_fwd_sel), .md_busy(md_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model: instructions in E(0), M(1), W(2) ----------------
  typedef struct {
    bit valid;
    bit wen;
    int wreg;
    int tnew0;
    int rs0;
    int rs1;
  } instr_t;

  instr_t pipe[3];
  int     md_rem;

  function automatic int ready_in(input int k);
    int r;
    r = pipe[k].tnew0 - k;
    return (r < 0) ? 0 : r;
  endfunction

  function automatic bit writes(input int k, input int r);
    return pipe[k].valid && pipe[k].wen && (pipe[k].wreg == r) && (r != 0);
  endfunction

  function automatic bit model_stall();
    bit s;
    s = 1'b0;
    for (int i = 0; i < NRP; i++) begin
      int r;
      int u;
      r = int'(d_rs[i*AW +: AW]);
      u = int'(d_tuse[i*TW +: TW]);
      for (int k = 0; k < 2; k++)
        if (writes(k, r) && ready_in(k) > u) s = 1'b1;
    end
    s = s && d_valid;
`ifdef MDU_STALL_EN
    if (d_md_use && (md_rem > 0 || e_md_start)) s = 1'b1;
`endif
    return s;
  endfunction

  function automatic int model_sel(input int i);
    int r;
    r = (i == 0) ? pipe[0].rs0 : pipe[0].rs1;
    if (writes(1, r) && ready_in(1) == 0) return 1;
    if (writes(2, r)) return 2;
    return 0;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 3; k++) pipe[k] = '{default: 0};
    md_rem = 0;
  endtask

  task automatic model_clock(input bit st);
    if (reset) begin
      model_clear();
    end else begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      if (st || !d_valid) pipe[0] = '{default: 0};
      else pipe[0] = '{1'b1, d_wen, int'(d_wreg), int'(d_tnew),
                       int'(d_rs[AW-1:0]), int'(d_rs[2*AW-1:AW])};
`ifdef MDU_STALL_EN
      if (e_md_start) md_rem = e_md_div ? 10 : 5;
      else if (md_rem > 0) md_rem--;
`endif
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        dv;
    logic [4:0]  rs0;
    logic [4:0]  rs1;
    logic [1:0]  tu0;
    logic [1:0]  tu1;
    logic        wen;
    logic [4:0]  wreg;
    logic [1:0]  tnew;
    logic [31:0] mdat;
    logic        st;
    logic [1:0]  s0;
    logic [1:0]  s1;
    logic        chk_op;
  } vec_t;

  vec_t vt[15];

  task automatic drive_d(input logic dv, input logic [4:0] r0, input logic [4:0] r1,
                         input logic [1:0] u0, input logic [1:0] u1,
                         input logic wen, input logic [4:0] wreg, input logic [1:0] tnew);
    d_valid = dv;
    d_rs    = {r1, r0};
    d_tuse  = {u1, u0};
    d_wen   = wen;
    d_wreg  = wreg;
    d_tnew  = tnew;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_clear();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    drive_d(1'b0, 5'd0, 5'd0, 2'd0, 2'd0, 1'b0, 5'd0, 2'd0);
    d_md_use = 1'b0; e_md_start = 1'b0; e_md_div = 1'b0;
    e_rf = {RF1, RF0};
    e_fwd_data = 32'h0; m_fwd_data = 32'h1234_5678; w_fwd_data = W_DATA;
    model_clear();

    //          dv  rs0   rs1   tu0  tu1  wen wreg  tnew mdat          st  s0 s1 chk
    vt[0]  = '{1'b0, 5'd1, 5'd2, 2'd0, 2'd0, 1'b0, 5'd0, 2'd0, 32'h1234_5678, 1'b0, 2'd0, 2'd0, 1'b1};
    vt[1]  = '{1'b1, 5'd0, 5'd0, 2'd0, 2'd0, 1'b1, 5'd3, 2'd2, 32'h1234_5678, 1'b0, 2'd0, 2'd0, 1'b0};
    vt[2]  = '{1'b1, 5'd3, 5'd3, 2'd1, 2'd1, 1'b1, 5'd4, 2'd1, 32'h1234_5678, 1'b1, 2'd0, 2'd0, 1'b1};
    vt[3]  = '{1'b1, 5'd3, 5'd3, 2'd1, 2'd1, 1'b1, 5'd4, 2'd1, 32'h1234_5678, 1'b0, 2'd0, 2'd0, 1'b0};
    vt[4]  = '{1'b1, 5'd1, 5'd2, 2'd1, 2'd1, 1'b1, 5'd5, 2'd1, 32'h1234_5678, 1'b0, 2'd2, 2'd2, 1'b1};
    vt[5]  = '{1'b1, 5'd5, 5'd0, 2'd1, 2'd1, 1'b1, 5'd6, 2'd1, 32'h1234_5678, 1'b0, 2'd0, 2'd0, 1'b1};
    vt[6]  = '{1'b1, 5'd0, 5'd0, 2'd0, 2'd0, 1'b1, 5'd31, 2'd0, 32'h1234_5678, 1'b0, 2'd1, 2'd0, 1'b1};
    vt[7]  = '{1'b1, 5'd31, 5'd0, 2'd0, 2'd0, 1'b0, 5'd0, 2'd0, 32'h1234_5678, 1'b0, 2'd0, 2'd0, 1'b1};
    vt[8]  = '{1'b0, 5'd0, 5'd0, 2'd0, 2'd0, 1'b0, 5'd0, 2'd0, 32'h0000_3008, 1'b0, 2'd1, 2'd0, 1'b1};
    vt[9]  = '{1'b1, 5'd0, 5'd0, 2'd0, 2'd0, 1'b1, 5'd7, 2'd1, 32'h1234_5678, 1'b0, 2'd0, 2'd0, 1'b0};
    vt[10] = '{1'b1, 5'd0, 5'd0, 2'd0, 2'd0, 1'b1, 5'd7, 2'd1, 32'h1234_5678, 1'b0, 2'd0, 2'd0, 1'b1};
    vt[11] = '{1'b1, 5'd7, 5'd0, 2'd1, 2'd1, 1'b0, 5'd0, 2'd0, 32'h1234_5678, 1'b0, 2'd0, 2'd0, 1'b1};
    vt[12] = '{1'b1, 5'd0, 5'd0, 2'd0, 2'd0, 1'b1, 5'd0, 2'd2, 32'h1234_5678, 1'b0, 2'd1, 2'd0, 1'b1};
    vt[13] = '{1'b1, 5'd0, 5'd0, 2'd0, 2'd0, 1'b0, 5'd0, 2'd0, 32'h1234_5678, 1'b0, 2'd0, 2'd0, 1'b1};
    vt[14] = '{1'b0, 5'd0, 5'd0, 2'd0, 2'd0, 1'b0, 5'd0, 2'd0, 32'h1234_5678, 1'b0, 2'd0, 2'd0, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      logic [31:0] exp0;
      logic [31:0] exp1;
      drive_d(vt[i].dv, vt[i].rs0, vt[i].rs1, vt[i].tu0, vt[i].tu1,
              vt[i].wen, vt[i].wreg, vt[i].tnew);
      m_fwd_data = vt[i].mdat;
      exp0 = (vt[i].s0 == 2'd1) ? vt[i].mdat : (vt[i].s0 == 2'd2) ? W_DATA : RF0;
      exp1 = (vt[i].s1 == 2'd1) ? vt[i].mdat : (vt[i].s1 == 2'd2) ? W_DATA : RF1;
      #4;
      chk($sformatf("vec%0d_stall", i), 32'(stall), 32'(vt[i].st));
      if (vt[i].chk_op) begin
        chk($sformatf("vec%0d_sel0", i), 32'(e_fwd_sel[1:0]), 32'(vt[i].s0));
        chk($sformatf("vec%0d_sel1", i), 32'(e_fwd_sel[3:2]), 32'(vt[i].s1));
        chk($sformatf("vec%0d_opnd0", i), e_opnd[31:0], exp0);
        chk($sformatf("vec%0d_opnd1", i), e_opnd[63:32], exp1);
      end
      tick();
    end
    chk("reset_md_busy", 32'(md_busy), 32'd0);

    // Reset in the middle of a load-use stall clears the pipeline.
    m_fwd_data = 32'h1234_5678;
    pulse_reset();
    drive_d(1'b1, 5'd0, 5'd0, 2'd0, 2'd0, 1'b1, 5'd3, 2'd2);
    #4 chk("rst_stall_lw", 32'(stall), 32'd0);
    tick();
    drive_d(1'b1, 5'd3, 5'd3, 2'd0, 2'd0, 1'b0, 5'd0, 2'd0);
    #4 chk("rst_stall_pre", 32'(stall), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #4 chk("rst_stall_post", 32'(stall), 32'd0);
    tick();
    drive_d(1'b0, 5'd0, 5'd0, 2'd0, 2'd0, 1'b0, 5'd0, 2'd0);
    #4 chk("rst_stall_sel", 32'(e_fwd_sel), 32'd0);
    chk("rst_stall_opnd", e_opnd[31:0], RF0);
    tick();

    // Mult/div busy sequences.
    pulse_reset();
`ifdef MDU_STALL_EN
    drive_d(1'b1, 5'd0, 5'd0, 2'd0, 2'd0, 1'b0, 5'd0, 2'd0);
    d_md_use = 1'b1; e_md_start = 1'b1; e_md_div = 1'b1;
    #4 chk("div_start_stall", 32'(stall), 32'd1);
    chk("div_start_busy", 32'(md_busy), 32'd0);
    tick();
    e_md_start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      #4 chk($sformatf("div_c%0d_stall", c), 32'(stall), 32'd1);
      chk($sformatf("div_c%0d_busy", c), 32'(md_busy), 32'd1);
      tick();
    end
    #4 chk("div_end_stall", 32'(stall), 32'd0);
    chk("div_end_busy", 32'(md_busy), 32'd0);
    tick();
    d_md_use = 1'b0; e_md_start = 1'b1; e_md_div = 1'b0;
    #4 chk("mult_nouse_stall", 32'(stall), 32'd0);
    tick();
    e_md_start = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      #4 chk($sformatf("mult_c%0d_busy", c), 32'(md_busy), (c <= 5) ? 32'd1 : 32'd0);
      tick();
    end
    d_md_use = 1'b1; e_md_start = 1'b1; e_md_div = 1'b1;
    tick();
    e_md_start = 1'b0;
    repeat (3) tick();
    #4 chk("div_rst_pre_busy", 32'(md_busy), 32'd1);
    chk("div_rst_pre_stall", 32'(stall), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #4 chk("div_rst_post_busy", 32'(md_busy), 32'd0);
    chk("div_rst_post_stall", 32'(stall), 32'd0);
    tick();
`else
    drive_d(1'b1, 5'd0, 5'd0, 2'd0, 2'd0, 1'b0, 5'd0, 2'd0);
    d_md_use = 1'b1; e_md_start = 1'b1; e_md_div = 1'b1;
    #4 chk("nomdu_stall", 32'(stall), 32'd0);
    chk("nomdu_busy", 32'(md_busy), 32'd0);
    tick();
    e_md_start = 1'b0;
    #4 chk("nomdu_stall2", 32'(stall), 32'd0);
    chk("nomdu_busy2", 32'(md_busy), 32'd0);
    tick();
`endif
    d_md_use = 1'b0; e_md_start = 1'b0; e_md_div = 1'b0;

    // Randomized run against the reference model.
    pulse_reset();
    for (int n = 0; n < 3000; n++) begin
      bit st;
      reset = ($urandom_range(0, 199) == 0);
      drive_d(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              2'($urandom), 2'($urandom), 1'($urandom_range(0, 3) != 0),
              5'($urandom_range(0, 7)), 2'($urandom));
      e_rf = {$urandom, $urandom};
      m_fwd_data = $urandom;
      w_fwd_data = $urandom;
      e_fwd_data = $urandom;
      d_md_use = 1'($urandom_range(0, 3) == 0);
      e_md_div = 1'($urandom);
`ifdef MDU_STALL_EN
      e_md_start = (md_rem == 0) && ($urandom_range(0, 7) == 0);
`else
      e_md_start = 1'($urandom);
`endif
      #4;
      st = model_stall();
      chk("rnd_stall", 32'(stall), 32'(st));
      chk("rnd_md_busy", 32'(md_busy), 32'(md_rem > 0));
      if (pipe[0].valid) begin
        for (int i = 0; i < NRP; i++) begin
          int s;
          logic [31:0] exp;
          s = model_sel(i);
          exp = (s == 1) ? m_fwd_data : (s == 2) ? w_fwd_data : e_rf[i*DW +: DW];
          chk($sformatf("rnd%0d_sel%0d", n, i), 32'(e_fwd_sel[i*2 +: 2]), 32'(s));
          chk($sformatf("rnd%0d_opnd%0d", n, i), e_opnd[i*DW +: DW], exp);
        end
      end
      tick();
      model_clock(st);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
